prompt_sequencer: RTL and testbench
===================================

PROMPT_SEQUENCER -- requirements
Module: prompt_sequencer

Interface
REQ-001 SHALL have parameter NUM_Q, default 4: number of prompt sprite controllers sequenced (2..8).
REQ-002 SHALL have parameter FEEDBACK_FRAMES, default 60: frames the right/wrong background is held after an answer.
REQ-003 SHALL have parameter TIMEOUT_FRAMES, default 600: frames a prompt waits for an answer (used only with PROMPT_TIMEOUT_EN).
REQ-004 SHALL have ports `clk` (input, 1) as the single clock and `rst` (input, 1) as a synchronous active-high reset.
REQ-005 SHALL have port `hCount`, input, 10 bits: VGA horizontal counter (0..799).
REQ-006 SHALL have port `vCount`, input, 10 bits: VGA vertical counter (0..524).
REQ-007 SHALL have port `start`, input, 1 bit: single-cycle request to begin or restart a quiz.
REQ-008 SHALL have port `answer_valid`, input, 1 bit: single-cycle answer strobe.
REQ-009 SHALL have port `answer_correct`, input, 1 bit: qualifies `answer_valid`.
REQ-010 SHALL have port `q_en`, output, NUM_Q bits: one-hot or zero enable to the prompt controllers.
REQ-011 SHALL have port `background`, output, 12 bits: RGB444 fill colour passed to the prompt controllers.
REQ-012 SHALL have port `score`, output, 4 bits: count of correct answers.
REQ-013 SHALL have ports `busy` (output, 1: quiz in progress) and `done` (output, 1: quiz finished).

Function
REQ-014 SHALL generate frame_tick for exactly one cycle when hCount==799 and vCount==524.
REQ-015 SHALL register all outputs and change them only on the cycle following a frame_tick, so the display never tears mid-frame.
REQ-016 SHALL latch `start` pulses into a pending flag in IDLE or DONE, and SHALL ignore `start` in other states.
REQ-017 SHALL latch the first `answer_valid` (and its `answer_correct`) in SHOW into a one-entry slot, and SHALL drop later strobes until the slot is consumed; strobes outside SHOW are dropped.
REQ-018 SHALL, when a strobe coincides with frame_tick, consume it on that tick.
REQ-019 SHALL use FSM states IDLE, SHOW, FEEDBACK and DONE; transitions occur only on frame_tick.
REQ-020 SHALL, in IDLE, drive q_en=0 and background=BG_IDLE; with start pending, go to SHOW with idx=0, timer=0, score=0, and clear the pending flag.
REQ-021 SHALL, in SHOW, drive q_en=1<<idx and background=BG_NORMAL.
REQ-022 SHALL, in SHOW with the answer slot full, go to FEEDBACK, set result=correct, add correct to score and clear the slot; otherwise timer increments.
REQ-023 SHALL, in FEEDBACK, drive q_en=1<<idx and background=BG_RIGHT or BG_WRONG per result.
REQ-024 SHALL, after FEEDBACK_FRAMES ticks in FEEDBACK, go to DONE if idx==NUM_Q-1; otherwise increment idx, clear timer and go to SHOW.
REQ-025 SHALL, in DONE, drive q_en=0, background=BG_DONE and done=1, and hold score; with start pending, go to SHOW as from IDLE.
REQ-026 SHALL assert busy in SHOW and FEEDBACK only.
REQ-027 SHALL saturate score at NUM_Q and size timers to the larger of the frame parameters.

Reset
REQ-028 SHALL, on rst at any point including mid-quiz, go to IDLE with q_en=0, background=BG_IDLE, score=0, busy=0, done=0, timer=0, idx=0, and both latches cleared.

Configuration
REQ-029 SHALL, with PROMPT_TIMEOUT_EN defined, go from SHOW to FEEDBACK with result=wrong and no score change when timer reaches TIMEOUT_FRAMES-1 on a tick with the slot empty.
REQ-030 SHALL, without PROMPT_TIMEOUT_EN, wait in SHOW indefinitely and omit the timeout comparator.

Structure
REQ-031 SHALL take the colour constants BG_IDLE, BG_NORMAL, BG_RIGHT, BG_WRONG, BG_DONE, the state encoding and H_LAST=799 / V_LAST=524 from a shared package vga_pkg.
REQ-032 SHALL implement frame_tick in a sub-module frame_tick_gen, reusable by other VGA controllers.

Verification
REQ-033 SHALL cover: NUM_Q=2, FEEDBACK_FRAMES=2; start, then correct answers on each prompt -> q_en 01 then 10, then 00; BG_RIGHT held 2 frames each; score=2; done=1.
REQ-034 SHALL cover: answer_valid with correct=0 then correct=1 within one frame -> first wins, BG_WRONG, score=0.
REQ-035 SHALL cover: answer_valid on the frame_tick cycle -> FEEDBACK on the next cycle; answer while in FEEDBACK -> ignored, score unchanged.
REQ-036 SHALL cover: PROMPT_TIMEOUT_EN, TIMEOUT_FRAMES=3, no answer -> FEEDBACK/BG_WRONG after 3 ticks; without the macro, still in SHOW after 10 ticks.
REQ-037 SHALL cover: rst asserted in FEEDBACK with score=1 -> next cycle IDLE, all outputs at reset values; start during SHOW -> ignored.
REQ-038 SHALL cover: q_en and background toggle only on the cycle after hCount=799, vCount=524, never mid-frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: raster limits, fill colours and the prompt
// sequencer state encoding. Used by the frame tick generator and by the
// prompt sequencer.
package vga_pkg;

   // Last visible+blanking positions of the 800x525 raster
   localparam logic [9:0] H_LAST = 10'd799;
   localparam logic [9:0] V_LAST = 10'd524;

   // RGB444 fill colours handed to the prompt sprite controllers
   localparam logic [11:0] BG_IDLE   = 12'h000;
   localparam logic [11:0] BG_NORMAL = 12'h00F;
   localparam logic [11:0] BG_RIGHT  = 12'h0F0;
   localparam logic [11:0] BG_WRONG  = 12'hF00;
   localparam logic [11:0] BG_DONE   = 12'hFF0;

   // Quiz sequencer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHOW     = 2'd1,
      ST_FEEDBACK = 2'd2,
      ST_DONE     = 2'd3
   } seq_state_t;

   // Larger of two integers, used to size shared frame counters
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: flags the last pixel clock of a VGA frame.
// With free-running counters the flag is high for exactly one cycle per
// frame. Kept separate so other VGA controllers can reuse it.
module frame_tick_gen
   import vga_pkg::*;
(
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   output logic       frame_tick
);

   // Tick on the final raster position so state can update in blanking
   always_comb begin
      frame_tick = (hCount == H_LAST) && (vCount == V_LAST);
   end

endmodule

// File: rtl/prompt_sequencer.sv
// Prompt sequencer: steps a quiz through NUM_Q prompt sprite controllers,
// shows right/wrong feedback for FEEDBACK_FRAMES frames per answer and
// keeps a saturating score. All outputs are registered and only change on
// the cycle after the frame tick so the picture never tears.
//
// Optional feature: define PROMPT_TIMEOUT_EN to make an unanswered prompt
// time out after TIMEOUT_FRAMES frames and count as a wrong answer.
//
// Handshake: start, answer_valid and answer_correct are single-cycle
// strobes with no ready; a strobe that cannot be accepted in the current
// state is dropped, an accepted one is held until the next frame tick.
module prompt_sequencer
   import vga_pkg::*;
#(
   parameter int NUM_Q           = 4,
   parameter int FEEDBACK_FRAMES = 60,
   parameter int TIMEOUT_FRAMES  = 600
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       hCount,
   input  logic [9:0]       vCount,
   input  logic             start,
   input  logic             answer_valid,
   input  logic             answer_correct,
   output logic [NUM_Q-1:0] q_en,
   output logic [11:0]      background,
   output logic [3:0]       score,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   // One shared frame counter covers both feedback hold and prompt timeout
   localparam int TMAX = max_int(FEEDBACK_FRAMES, TIMEOUT_FRAMES);
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0]    FB_LAST  = TW'(FEEDBACK_FRAMES - 1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_Q - 1);
   localparam logic [3:0]       SCORE_MAX = 4'(NUM_Q);
   localparam logic [NUM_Q-1:0] Q_ONE    = NUM_Q'(1);

   seq_state_t    state;
   logic [2:0]    idx;
   logic [TW-1:0] timer;
   logic          start_pend;
   logic          ans_full;
   logic          ans_corr;
   logic          result;
   logic          frame_tick;

   logic          start_ok;
   logic          start_eff;
   logic          ans_eff_full;
   logic          ans_eff_corr;

   frame_tick_gen u_frame_tick_gen (
      .hCount     (hCount),
      .vCount     (vCount),
      .frame_tick (frame_tick)
   );

   // Effective latch contents, so a strobe on the tick cycle is used at once
   always_comb begin
      start_ok     = (state == ST_IDLE) || (state == ST_DONE);
      start_eff    = start_pend || (start && start_ok);
      ans_eff_full = ans_full || (answer_valid && (state == ST_SHOW));
      ans_eff_corr = ans_full ? ans_corr : answer_correct;
   end

   assign state_dbg = state;

   // Quiz FSM with input latches and registered display outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= 3'd0;
         timer      <= '0;
         start_pend <= 1'b0;
         ans_full   <= 1'b0;
         ans_corr   <= 1'b0;
         result     <= 1'b0;
         q_en       <= '0;
         background <= BG_IDLE;
         score      <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (!frame_tick) begin
         // Between ticks only the latches move; the first answer wins
         if (start && start_ok) begin
            start_pend <= 1'b1;
         end
         if (answer_valid && (state == ST_SHOW) && !ans_full) begin
            ans_full <= 1'b1;
            ans_corr <= answer_correct;
         end
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_eff) begin
                  state      <= ST_SHOW;
                  idx        <= 3'd0;
                  timer      <= '0;
                  start_pend <= 1'b0;
                  score      <= 4'd0;
                  q_en       <= Q_ONE;
                  background <= BG_NORMAL;
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end

            ST_SHOW: begin
               if (ans_eff_full) begin
                  state      <= ST_FEEDBACK;
                  result     <= ans_eff_corr;
                  timer      <= '0;
                  ans_full   <= 1'b0;
                  background <= ans_eff_corr ? BG_RIGHT : BG_WRONG;
                  if (ans_eff_corr && (score < SCORE_MAX)) begin
                     score <= score + 4'd1;
                  end
`ifdef PROMPT_TIMEOUT_EN
               end else if (timer == TW'(TIMEOUT_FRAMES - 1)) begin
                  state      <= ST_FEEDBACK;
                  result     <= 1'b0;
                  timer      <= '0;
                  background <= BG_WRONG;
`endif
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end

            ST_FEEDBACK: begin
               if (timer == FB_LAST) begin
                  timer <= '0;
                  if (idx == IDX_LAST) begin
                     state      <= ST_DONE;
                     q_en       <= '0;
                     background <= BG_DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     state      <= ST_SHOW;
                     idx        <= idx + 3'd1;
                     q_en       <= Q_ONE << (idx + 3'd1);
                     background <= BG_NORMAL;
                  end
               end else begin
                  timer      <= timer + 1'b1;
                  background <= result ? BG_RIGHT : BG_WRONG;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prompt_sequencer.sv
// Bench for prompt_sequencer with NUM_Q=2, FEEDBACK_FRAMES=2,
// TIMEOUT_FRAMES=3. Frames are compressed: a frame tick is one cycle with
// hCount=799/vCount=524, any other cycle is mid-frame.
module tb_prompt_sequencer;

   localparam logic [11:0] C_IDLE   = 12'h000;
   localparam logic [11:0] C_NORMAL = 12'h00F;
   localparam logic [11:0] C_RIGHT  = 12'h0F0;
   localparam logic [11:0] C_WRONG  = 12'hF00;
   localparam logic [11:0] C_DONE   = 12'hFF0;

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        st;
      logic        av;
      logic        ac;
      logic        rs;
      logic [1:0]  q;
      logic [11:0] bg;
      logic [3:0]  sc;
      logic        b;
      logic        d;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  hCount = 10'd0;
   logic [9:0]  vCount = 10'd0;
   logic        start = 1'b0;
   logic        answer_valid = 1'b0;
   logic        answer_correct = 1'b0;
   logic [1:0]  q_en;
   logic [11:0] background;
   logic [3:0]  score;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   vec_t        vec_q[$];
   logic [19:0] exp_q[$];
   int          total = 0;
   int          bad = 0;

   // clock / reset block
   always #5 clk = ~clk;

   prompt_sequencer #(
      .NUM_Q           (2),
      .FEEDBACK_FRAMES (2),
      .TIMEOUT_FRAMES  (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .hCount         (hCount),
      .vCount         (vCount),
      .start          (start),
      .answer_valid   (answer_valid),
      .answer_correct (answer_correct),
      .q_en           (q_en),
      .background     (background),
      .score          (score),
      .busy           (busy),
      .done           (done),
      .state_dbg      (state_dbg)
   );

   // driver: apply one cycle of inputs, return 1ns after the edge
   task automatic cyc(input logic [9:0] h, input logic [9:0] v,
                      input logic st, input logic av, input logic ac,
                      input logic rs);
      hCount = h; vCount = v; start = st;
      answer_valid = av; answer_correct = ac; rst = rs;
      @(posedge clk);
      #1;
      hCount = 10'd0; vCount = 10'd0; start = 1'b0;
      answer_valid = 1'b0; answer_correct = 1'b0; rst = 1'b0;
   endtask

   task automatic tick();
      cyc(10'd799, 10'd524, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic add(input logic [9:0] h, input logic [9:0] v,
                      input logic st, input logic av, input logic ac,
                      input logic rs, input logic [1:0] q,
                      input logic [11:0] bg, input logic [3:0] sc,
                      input logic b, input logic d);
      vec_t t;
      t.h = h; t.v = v; t.st = st; t.av = av; t.ac = ac; t.rs = rs;
      t.q = q; t.bg = bg; t.sc = sc; t.b = b; t.d = d;
      vec_q.push_back(t);
   endtask

   // scoreboard: compare outputs against the oldest expected entry
   task automatic check(input string name, input int n);
      logic [19:0] got;
      logic [19:0] exp;
      got = {q_en, background, score, busy, done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got q=%b bg=%h sc=%0d busy=%b done=%b want q=%b bg=%h sc=%0d busy=%b done=%b",
                  name, n, got[19:18], got[17:6], got[5:2], got[1], got[0],
                  exp[19:18], exp[17:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic expect_now(input string name, input int n,
                             input logic [1:0] q, input logic [11:0] bg,
                             input logic [3:0] sc, input logic b,
                             input logic d);
      exp_q.push_back({q, bg, sc, b, d});
      check(name, n);
   endtask

   initial begin
      // h    v    st av ac rs   q      bg        sc b d
      // reset and idle
      add(  0,   0, 0, 0, 0, 1, 2'b00, C_IDLE,   0, 0, 0);
      add(  0,   0, 0, 0, 0, 0, 2'b00, C_IDLE,   0, 0, 0);
      add( 10,   0, 1, 0, 0, 0, 2'b00, C_IDLE,   0, 0, 0);
      add(799, 100, 0, 0, 0, 0, 2'b00, C_IDLE,   0, 0, 0);
      // two correct answers, feedback held 2 frames each
      add(799, 524, 0, 0, 0, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(  5,   0, 0, 1, 1, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b01, C_RIGHT,  1, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b01, C_RIGHT,  1, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b10, C_NORMAL, 1, 1, 0);
      add(  0, 524, 0, 0, 0, 0, 2'b10, C_NORMAL, 1, 1, 0);
      add(300, 200, 0, 1, 1, 0, 2'b10, C_NORMAL, 1, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b10, C_RIGHT,  2, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b10, C_RIGHT,  2, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b00, C_DONE,   2, 0, 1);
      add(799, 524, 0, 0, 0, 0, 2'b00, C_DONE,   2, 0, 1);
      // restart from DONE; first of two answers in a frame wins
      add(  0,   0, 1, 0, 0, 0, 2'b00, C_DONE,   2, 0, 1);
      add(799, 524, 0, 0, 0, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(  1,   0, 0, 1, 0, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(  2,   0, 0, 1, 1, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b01, C_WRONG,  0, 1, 0);
      // answer during feedback is ignored
      add(  3,   0, 0, 1, 1, 0, 2'b01, C_WRONG,  0, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b01, C_WRONG,  0, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b10, C_NORMAL, 0, 1, 0);
      // answer on the tick cycle itself is taken on that tick
      add(799, 524, 0, 1, 1, 0, 2'b10, C_RIGHT,  1, 1, 0);
      // start during feedback is ignored
      add(  0,   0, 1, 0, 0, 0, 2'b10, C_RIGHT,  1, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b10, C_RIGHT,  1, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b00, C_DONE,   1, 0, 1);
      add(799, 524, 0, 0, 0, 0, 2'b00, C_DONE,   1, 0, 1);
      // start during SHOW ignored; reset mid-feedback with score 1
      add(  0,   0, 1, 0, 0, 0, 2'b00, C_DONE,   1, 0, 1);
      add(799, 524, 0, 0, 0, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(  7,   0, 1, 0, 0, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(  8,   0, 0, 1, 1, 0, 2'b01, C_NORMAL, 0, 1, 0);
      add(799, 524, 0, 0, 0, 0, 2'b01, C_RIGHT,  1, 1, 0);
      add(  0,   0, 0, 0, 0, 1, 2'b00, C_IDLE,   0, 0, 0);
      add(799, 524, 0, 0, 0, 0, 2'b00, C_IDLE,   0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < vec_q.size(); i++) begin
         exp_q.push_back({vec_q[i].q, vec_q[i].bg, vec_q[i].sc,
                          vec_q[i].b, vec_q[i].d});
         cyc(vec_q[i].h, vec_q[i].v, vec_q[i].st, vec_q[i].av,
             vec_q[i].ac, vec_q[i].rs);
         check("vec", i);
      end

      // timeout behaviour: unanswered prompt
      cyc(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      expect_now("to_enter", 0, 2'b01, C_NORMAL, 4'd0, 1'b1, 1'b0);
`ifdef PROMPT_TIMEOUT_EN
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i < 3)
            expect_now("to_wait", i, 2'b01, C_NORMAL, 4'd0, 1'b1, 1'b0);
         else
            expect_now("to_fire", i, 2'b01, C_WRONG, 4'd0, 1'b1, 1'b0);
      end
`else
      for (int i = 1; i <= 10; i++) begin
         tick();
         expect_now("no_to", i, 2'b01, C_NORMAL, 4'd0, 1'b1, 1'b0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
